// File: rtl/reset_sequencer.sv
// Board reset/clock-enable controller: synchronizes RESET and locked, releases
// STAGES active-low domain resets in order, and generates a divided tick enable.
module reset_sequencer #(
   parameter int HOLD_CYCLES = 16,
   parameter int STAGES      = 3,
   parameter int GAP_CYCLES  = 4,
   parameter int DIV_W       = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               locked,
   input  logic               soft_req,
   input  logic [DIV_W-1:0]   div,
   output logic [STAGES-1:0]  resetn,
   output logic               ready,
   output logic               soft_ack,
   output logic               tick
);

   localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK,
      HOLD,
      RELEASE,
      RUN,
      SOFT
   } state_t;

   state_t            state;
   logic [1:0]        rst_sync;
   logic [1:0]        lock_sync;
   logic              rst_int;
   logic              locked_s;
   logic [CW-1:0]     cnt;
   logic [DIV_W-1:0]  tcnt;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rst_sync  <= '1;
         lock_sync <= '0;
      end else begin
         rst_sync  <= {rst_sync[0], 1'b0};
         lock_sync <= {lock_sync[0], locked};
      end
   end

   assign rst_int  = rst_sync[1];
   assign locked_s = lock_sync[1];

   // The last-released domain bit doubles as the stage counter: resetn only
   // ever fills from bit 0 upward, so its top bit marks the end of RELEASE.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= WAIT_LOCK;
         cnt      <= '0;
         resetn   <= '0;
         ready    <= 1'b0;
         soft_ack <= 1'b0;
      end else if (state != WAIT_LOCK && !locked_s) begin
         state    <= WAIT_LOCK;
         cnt      <= '0;
         resetn   <= '0;
         ready    <= 1'b0;
         soft_ack <= 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: begin
               cnt      <= '0;
               resetn   <= '0;
               ready    <= 1'b0;
               soft_ack <= 1'b0;
               if (locked_s && !rst_int) state <= HOLD;
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state  <= RELEASE;
                  resetn <= STAGES'(1);
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RELEASE: begin
               if (resetn[STAGES-1]) begin
                  state <= RUN;
                  ready <= 1'b1;
                  cnt   <= '0;
               end else if (cnt == GAP_LAST) begin
                  resetn <= (resetn << 1) | STAGES'(1);
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (soft_req) begin
                  state    <= SOFT;
                  resetn   <= '0;
                  ready    <= 1'b0;
                  soft_ack <= 1'b1;
               end
            end
            SOFT: begin
               if (!soft_req) begin
                  state    <= HOLD;
                  soft_ack <= 1'b0;
                  cnt      <= '0;
               end
            end
            default: state <= WAIT_LOCK;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         tcnt <= '0;
      else if (!ready)
         tcnt <= '0;
      else if (tcnt >= div)
         tcnt <= '0;
      else
         tcnt <= tcnt + 1'b1;
   end

   assign tick = ready & (tcnt >= div);

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random
// lock/soft/div/RESET activity against an edge-time reference model.
module tb_reset_sequencer;

   localparam int HOLD  = 16;
   localparam int STG   = 3;
   localparam int GAP   = 4;
   localparam int DW    = 8;
   localparam int R_OFF = HOLD + (STG - 1) * GAP + 1;

   logic            CLK = 1'b0;
   logic            RESET = 1'b1;
   logic            locked = 1'b0;
   logic            soft_req = 1'b0;
   logic [DW-1:0]   div = '0;
   logic [STG-1:0]  resetn;
   logic            ready;
   logic            soft_ack;
   logic            tick;

   reset_sequencer #(
      .HOLD_CYCLES (HOLD),
      .STAGES      (STG),
      .GAP_CYCLES  (GAP),
      .DIV_W       (DW)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .locked   (locked),
      .soft_req (soft_req),
      .div      (div),
      .resetn   (resetn),
      .ready    (ready),
      .soft_ack (soft_ack),
      .tick     (tick)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // Model: edge index since RESET release, and the edge at which the current
   // release sequence (HOLD entry) began; outputs follow from edge arithmetic.
   typedef enum {M_IDLE, M_SEQ, M_SOFT} mode_t;
   mode_t mode;
   int    n;
   int    start;
   int    since;
   bit    p1, p2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
      end
   endtask

   function automatic bit exp_ready();
      return (mode == M_SEQ) && (n >= start + R_OFF);
   endfunction

   function automatic logic [STG-1:0] exp_resetn();
      logic [STG-1:0] v;
      for (int i = 0; i < STG; i++)
         v[i] = (mode == M_SEQ) && (n >= start + HOLD + i * GAP);
      return v;
   endfunction

   function automatic bit exp_tick();
      return exp_ready() && (since >= int'(div));
   endfunction

   task automatic model_reset();
      mode  = M_IDLE;
      n     = 0;
      start = 0;
      since = 0;
      p1    = 1'b0;
      p2    = 1'b0;
   endtask

   task automatic model_edge();
      bit rb, ls;
      rb = exp_ready();
      n++;
      ls = (n >= 3) ? p2 : 1'b0;
      p2 = p1;
      p1 = locked;
      if (!rb)                      since = 0;
      else if (since >= int'(div))  since = 0;
      else                          since++;
      case (mode)
         M_IDLE: if (ls) begin mode = M_SEQ; start = n; end
         default: begin
            if (!ls)
               mode = M_IDLE;
            else if (mode == M_SEQ && rb && soft_req)
               mode = M_SOFT;
            else if (mode == M_SOFT && !soft_req) begin
               mode  = M_SEQ;
               start = n;
            end
         end
      endcase
   endtask

   task automatic check_all();
      chk("resetn",   32'(resetn),   32'(exp_resetn()));
      chk("ready",    32'(ready),    32'(exp_ready()));
      chk("soft_ack", 32'(soft_ack), 32'(mode == M_SOFT));
      chk("tick",     32'(tick),     32'(exp_tick()));
   endtask

   task automatic step();
      @(posedge CLK);
      if (!RESET) model_edge();
      #1;
      check_all();
   endtask

   // Asynchronous RESET pulse starting away from any clock edge.
   task automatic do_reset();
      RESET = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic run_from_reset();
      for (int e = 1; e <= 45; e++) begin
         step();
         if (e == 18) chk("pu_rn_e18", 32'(resetn), 32'd0);
         if (e == 19) chk("pu_rn_e19", 32'(resetn), 32'd1);
         if (e == 23) chk("pu_rn_e23", 32'(resetn), 32'd3);
         if (e == 27) chk("pu_rn_e27", 32'(resetn), 32'd7);
         if (e == 27) chk("pu_rdy_e27", 32'(ready), 32'd0);
         if (e == 28) chk("pu_rdy_e28", 32'(ready), 32'd1);
         if (e == 30) chk("pu_tick_e30", 32'(tick), 32'd0);
         if (e == 31) chk("pu_tick_e31", 32'(tick), 32'd1);
         if (e == 35) chk("pu_tick_e35", 32'(tick), 32'd1);
      end
   endtask

   initial begin
      int lock_low;
      int guard;

      model_reset();
      RESET = 1'b1;
      locked = 1'b1;
      div = 8'd3;
      repeat (3) @(posedge CLK);
      #1;
      check_all();
      @(negedge CLK);
      RESET = 1'b0;
      run_from_reset();

      // RESET mid-RELEASE: outputs clear with no clock edge needed
      do_reset();
      repeat (21) step();
      RESET = 1'b1;
      #1;
      chk("async_rn",    32'(resetn),   32'd0);
      chk("async_ready", 32'(ready),    32'd0);
      chk("async_ack",   32'(soft_ack), 32'd0);
      chk("async_tick",  32'(tick),     32'd0);
      model_reset();
      @(negedge CLK);
      RESET = 1'b0;
      run_from_reset();

      // lock held low after reset, then raised
      locked = 1'b0;
      do_reset();
      repeat (50) step();
      locked = 1'b1;
      repeat (40) step();

      // soft reset from RUN
      soft_req = 1'b1;
      repeat (5) step();
      soft_req = 1'b0;
      repeat (45) step();

      // soft_req during RELEASE is ignored
      do_reset();
      repeat (21) step();
      soft_req = 1'b1;
      repeat (2) step();
      soft_req = 1'b0;
      repeat (20) step();

      // one-cycle lock loss coinciding with soft_req
      locked = 1'b0;
      soft_req = 1'b1;
      step();
      locked = 1'b1;
      repeat (4) step();
      soft_req = 1'b0;
      repeat (40) step();

      // divisor corner cases
      div = 8'd0;
      repeat (20) step();
      div = 8'd200;
      guard = 0;
      while (since != 100 && guard < 450) begin
         step();
         guard++;
      end
      chk("div_wait", 32'(since == 100), 32'd1);
      div = 8'd2;
      #1;
      chk("div_drop_tick", 32'(tick), 32'(exp_tick()));
      repeat (12) step();
      div = 8'd255;
      repeat (600) step();

      // randomized activity
      lock_low = 0;
      for (int c = 0; c < 1500; c++) begin
         int r;
         r = $urandom_range(0, 999);
         if (r < 8) begin
            do_reset();
         end else begin
            if (r < 30 && lock_low == 0) lock_low = $urandom_range(1, 4);
            if ($urandom_range(0, 99) < 3) soft_req = ~soft_req;
            if ($urandom_range(0, 99) < 2) div = DW'($urandom_range(0, 6));
         end
         if (lock_low > 0) begin
            locked = 1'b0;
            lock_low--;
         end else begin
            locked = 1'b1;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
